// File: rtl/ysyx_23060042_ctrl.sv
// ysyx_23060042_ctrl: multi-cycle core control FSM.
// It sequences instruction fetch, decode, an optional load/store and write-back.
// A shared wait counter turns a stalled fetch or LSU handshake into a sticky
// ERROR state after MEM_TIMEOUT idle cycles.
// Optional feature macro: YSYX_23060042_PERF_EN adds the mcycle/minstret
// performance counters as extra output ports.
//
// Handshake semantics:
// - ifu_req and ifu_rvalid: ifu_req is high for every FETCH cycle. The first
//   cycle in which ifu_rvalid is high completes the fetch, and inst_in is
//   captured at that edge.
// - lsu_req and lsu_done: lsu_req is high for every MEM cycle. The first cycle
//   in which lsu_done is high completes the access.
// - ifu_rvalid outside FETCH and lsu_done outside MEM have no effect.
module ysyx_23060042_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req,
    input  logic        ifu_rvalid,
    input  logic [31:0] inst_in,
    output logic [31:0] inst,
    input  logic        Regen,
    input  logic        Pcjen,
    input  logic [1:0]  Mwen,
    input  logic [1:0]  Mren,
    input  logic        Brken,
    output logic        lsu_req,
    input  logic        lsu_done,
    output logic        reg_we,
    output logic        pc_we,
    output logic        halt,
    output logic        err,
    output logic [2:0]  state
`ifdef YSYX_23060042_PERF_EN
    ,
    output logic [63:0] mcycle,
    output logic [63:0] minstret
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERROR  = 3'd6
    } state_e;

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_V = CW'(MEM_TIMEOUT);
    localparam logic [31:0] NOP = 32'h0000_0013;

    state_e        state_q, state_d;
    logic [31:0]   inst_q, inst_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ifu_req_q, ifu_req_d;
    logic          lsu_req_q, lsu_req_d;
    logic          reg_we_q, reg_we_d;
    logic          pc_we_q, pc_we_d;
    logic          halt_q, halt_d;
    logic          err_q, err_d;

    // The PC is written on every WB. Pcjen only selects the jump target in the
    // PC datapath, so the control sequence itself never looks at it.
    logic pcjen_unused;
    assign pcjen_unused = Pcjen;

    // Next-state, instruction latch and wait-counter logic.
    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                cnt_d   = '0;
            end
            S_FETCH: begin
                // A handshake in the same cycle as the timeout count wins.
                if (ifu_rvalid) begin
                    inst_d  = inst_in;
                    state_d = S_DECODE;
                end else if (cnt_q == TIMEOUT_V) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DECODE: begin
                if (Brken) begin
                    state_d = S_HALT;
                end else if ((Mren != 2'b00) || (Mwen != 2'b00)) begin
                    state_d = S_MEM;
                    cnt_d   = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (lsu_done) begin
                    state_d = S_WB;
                end else if (cnt_q == TIMEOUT_V) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                cnt_d   = '0;
            end
            S_HALT:  state_d = S_HALT;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase
    end

    // Outputs are registered, so each one is decoded from the next state.
    // Regen is stable from DECODE through WB because inst only changes on a fetch.
    always_comb begin
        ifu_req_d = (state_d == S_FETCH);
        lsu_req_d = (state_d == S_MEM);
        pc_we_d   = (state_d == S_WB);
        reg_we_d  = (state_d == S_WB) && Regen;
        halt_d    = (state_d == S_HALT);
        err_d     = (state_d == S_ERROR);
    end

`ifdef YSYX_23060042_PERF_EN
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    // Cycle counter freezes in HALT/ERROR. Retired count bumps once per WB.
    // Both wrap naturally at 2^64.
    always_comb begin
        mcycle_d   = mcycle_q;
        minstret_d = minstret_q;
        if ((state_q != S_HALT) && (state_q != S_ERROR)) begin
            mcycle_d = mcycle_q + 64'd1;
        end
        if (state_q == S_WB) begin
            minstret_d = minstret_q + 64'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign mcycle   = mcycle_q;
    assign minstret = minstret_q;
`endif

    // FSM state, instruction register, wait counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            inst_q    <= NOP;
            cnt_q     <= '0;
            ifu_req_q <= 1'b0;
            lsu_req_q <= 1'b0;
            reg_we_q  <= 1'b0;
            pc_we_q   <= 1'b0;
            halt_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            cnt_q     <= cnt_d;
            ifu_req_q <= ifu_req_d;
            lsu_req_q <= lsu_req_d;
            reg_we_q  <= reg_we_d;
            pc_we_q   <= pc_we_d;
            halt_q    <= halt_d;
            err_q     <= err_d;
        end
    end

    assign state   = state_q;
    assign inst    = inst_q;
    assign ifu_req = ifu_req_q;
    assign lsu_req = lsu_req_q;
    assign reg_we  = reg_we_q;
    assign pc_we   = pc_we_q;
    assign halt    = halt_q;
    assign err     = err_q;

endmodule

// File: tb/tb_ysyx_23060042_ctrl.sv
// Testbench for ysyx_23060042_ctrl. Built with MEM_TIMEOUT=4 so that the
// timeout boundary is reachable in a few cycles. Define YSYX_23060042_PERF_EN
// to also exercise mcycle/minstret.
module tb_ysyx_23060042_ctrl;

    localparam int TO = 4;
    localparam int EW = 41;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifu_req;
    logic        ifu_rvalid = 1'b0;
    logic [31:0] inst_in = 32'h0;
    logic [31:0] inst;
    logic        Regen = 1'b0;
    logic        Pcjen = 1'b0;
    logic [1:0]  Mwen = 2'b00;
    logic [1:0]  Mren = 2'b00;
    logic        Brken = 1'b0;
    logic        lsu_req;
    logic        lsu_done = 1'b0;
    logic        reg_we;
    logic        pc_we;
    logic        halt;
    logic        err;
    logic [2:0]  state;
`ifdef YSYX_23060042_PERF_EN
    logic [63:0] mcycle;
    logic [63:0] minstret;
`endif

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    ysyx_23060042_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req), .ifu_rvalid(ifu_rvalid), .inst_in(inst_in), .inst(inst),
        .Regen(Regen), .Pcjen(Pcjen), .Mwen(Mwen), .Mren(Mren), .Brken(Brken),
        .lsu_req(lsu_req), .lsu_done(lsu_done),
        .reg_we(reg_we), .pc_we(pc_we), .halt(halt), .err(err), .state(state)
`ifdef YSYX_23060042_PERF_EN
        , .mcycle(mcycle), .minstret(minstret)
`endif
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [31:0]   exp_inst;
    int            total = 0;
    int            bad = 0;

    typedef struct {
        logic [31:0] word;
        logic        regen;
        logic        pcjen;
        logic [1:0]  mwen;
        logic [1:0]  mren;
        int          fw;   // idle FETCH cycles before rvalid
        int          lw;   // idle MEM cycles before lsu_done
    } vec_t;

    vec_t tbl[8];

    task automatic expect_push(input logic [2:0] st, input logic i_req, input logic l_req,
                               input logic rw, input logic pw, input logic h, input logic e);
        exp_q.push_back({st, i_req, l_req, rw, pw, h, e, exp_inst});
    endtask

    task automatic check_cycle(input string name);
        logic [EW-1:0] act;
        logic [EW-1:0] exp;
        act = {state, ifu_req, lsu_req, reg_we, pc_we, halt, err, inst};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: no expected entry, got %h", name, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                bad++;
                $display("FAIL %s: got st=%0d ifu/lsu/rw/pw/h/e=%b inst=%h, want st=%0d ifu/lsu/rw/pw/h/e=%b inst=%h",
                         name, act[40:38], act[37:32], act[31:0], exp[40:38], exp[37:32], exp[31:0]);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after the edge that enters FETCH.
    task automatic do_reset(input string name);
        rst = 1'b1;
        ifu_rvalid = 1'b0;
        lsu_done = 1'b0;
        Brken = 1'b0;
        #1;
        exp_inst = 32'h0000_0013;
        expect_push(3'd0, 0, 0, 0, 0, 0, 0);
        check_cycle({name, "/async"});
        tick();
        expect_push(3'd0, 0, 0, 0, 0, 0, 0);
        check_cycle({name, "/hold"});
        rst = 1'b0;
        #1;
        expect_push(3'd0, 0, 0, 0, 0, 0, 0);
        check_cycle({name, "/idle"});
        tick();
    endtask

    // Runs one full instruction starting in the first FETCH cycle.
    task automatic run_instr(input vec_t v, input string name);
        Regen = v.regen;
        Pcjen = v.pcjen;
        Mwen  = v.mwen;
        Mren  = v.mren;
        Brken = 1'b0;
        for (int k = 0; k <= v.fw; k++) begin
            expect_push(3'd1, 1, 0, 0, 0, 0, 0);
            check_cycle({name, "/fetch"});
            ifu_rvalid = (k == v.fw);
            inst_in    = (k == v.fw) ? v.word : $urandom;
            lsu_done   = 1'($urandom_range(0, 1));
            tick();
        end
        exp_inst = v.word;
        expect_push(3'd2, 0, 0, 0, 0, 0, 0);
        check_cycle({name, "/decode"});
        ifu_rvalid = 1'($urandom_range(0, 1));
        inst_in    = $urandom;
        lsu_done   = 1'($urandom_range(0, 1));
        tick();
        if ((v.mwen != 2'b00) || (v.mren != 2'b00)) begin
            for (int k = 0; k <= v.lw; k++) begin
                expect_push(3'd3, 0, 1, 0, 0, 0, 0);
                check_cycle({name, "/mem"});
                lsu_done   = (k == v.lw);
                ifu_rvalid = 1'($urandom_range(0, 1));
                inst_in    = $urandom;
                tick();
            end
        end
        expect_push(3'd4, 0, 0, v.regen, 1, 0, 0);
        check_cycle({name, "/wb"});
        ifu_rvalid = 1'($urandom_range(0, 1));
        lsu_done   = 1'($urandom_range(0, 1));
        tick();
        ifu_rvalid = 1'b0;
        lsu_done   = 1'b0;
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t v;
        exp_inst = 32'h0000_0013;
        // word, regen, pcjen, mwen, mren, fw, lw
        tbl[0] = '{32'h0010_0093, 1'b1, 1'b0, 2'b00, 2'b00, 0, 0};   // addi, immediate rvalid
        tbl[1] = '{32'h0000_a103, 1'b1, 1'b0, 2'b00, 2'b01, 2, 3};   // lw, done 3 cycles into MEM
        tbl[2] = '{32'h0020_a023, 1'b0, 1'b0, 2'b11, 2'b00, 1, 0};   // sw
        tbl[3] = '{32'h0050_0113, 1'b1, 1'b0, 2'b00, 2'b00, TO, 0};  // rvalid at the timeout count
        tbl[4] = '{32'h0000_8183, 1'b1, 1'b0, 2'b00, 2'b01, 0, TO};  // lb, done at the timeout count
        tbl[5] = '{32'h0080_00ef, 1'b1, 1'b1, 2'b00, 2'b00, 1, 0};   // jal
        tbl[6] = '{32'h0030_9023, 1'b0, 1'b0, 2'b01, 2'b00, 3, 2};   // sh
        tbl[7] = '{32'h0020_8463, 1'b0, 1'b1, 2'b00, 2'b00, 3, 0};   // beq

        #2;
        do_reset("reset0");

        for (int i = 0; i < 8; i++) begin
            run_instr(tbl[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 6; i++) begin
            int kind;
            kind    = $urandom_range(0, 2);
            v.word  = $urandom;
            v.regen = 1'($urandom_range(0, 1));
            v.pcjen = 1'($urandom_range(0, 1));
            v.mren  = (kind == 1) ? 2'($urandom_range(1, 3)) : 2'b00;
            v.mwen  = (kind == 2) ? 2'($urandom_range(1, 3)) : 2'b00;
            v.fw    = $urandom_range(0, TO);
            v.lw    = $urandom_range(0, TO);
            run_instr(v, $sformatf("rand%0d", i));
        end

        // ebreak: Brken beats a memory op in DECODE, HALT is sticky.
        Regen = 1'b0; Mren = 2'b01; Mwen = 2'b00; Brken = 1'b1;
        expect_push(3'd1, 1, 0, 0, 0, 0, 0);
        check_cycle("ebreak/fetch");
        ifu_rvalid = 1'b1; inst_in = 32'h0010_0073;
        tick();
        exp_inst = 32'h0010_0073;
        ifu_rvalid = 1'b0;
        expect_push(3'd2, 0, 0, 0, 0, 0, 0);
        check_cycle("ebreak/decode");
        tick();
        for (int k = 0; k < 100; k++) begin
            expect_push(3'd5, 0, 0, 0, 0, 1, 0);
            check_cycle("ebreak/halt");
            ifu_rvalid = 1'($urandom_range(0, 1));
            inst_in    = $urandom;
            lsu_done   = 1'($urandom_range(0, 1));
            tick();
        end
        do_reset("reset_halt");

        // Fetch timeout: five FETCH cycles without rvalid, then sticky ERROR.
        Mren = 2'b00; Mwen = 2'b00;
        for (int k = 0; k <= TO; k++) begin
            expect_push(3'd1, 1, 0, 0, 0, 0, 0);
            check_cycle("ftimeout/fetch");
            lsu_done = 1'($urandom_range(0, 1));
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            expect_push(3'd6, 0, 0, 0, 0, 0, 1);
            check_cycle("ftimeout/error");
            ifu_rvalid = 1'($urandom_range(0, 1));
            inst_in    = $urandom;
            tick();
        end
        do_reset("reset_ferr");

        // LSU timeout.
        Regen = 1'b1; Mwen = 2'b01;
        expect_push(3'd1, 1, 0, 0, 0, 0, 0);
        check_cycle("mtimeout/fetch");
        ifu_rvalid = 1'b1; inst_in = 32'h00a1_2023;
        tick();
        exp_inst = 32'h00a1_2023;
        ifu_rvalid = 1'b0;
        expect_push(3'd2, 0, 0, 0, 0, 0, 0);
        check_cycle("mtimeout/decode");
        tick();
        for (int k = 0; k <= TO; k++) begin
            expect_push(3'd3, 0, 1, 0, 0, 0, 0);
            check_cycle("mtimeout/mem");
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            expect_push(3'd6, 0, 0, 0, 0, 0, 1);
            check_cycle("mtimeout/error");
            lsu_done = 1'($urandom_range(0, 1));
            tick();
        end
        do_reset("reset_merr");

        // Reset in the middle of MEM: outputs clear in the same cycle.
        Regen = 1'b1; Mwen = 2'b00; Mren = 2'b01;
        expect_push(3'd1, 1, 0, 0, 0, 0, 0);
        check_cycle("midmem/fetch");
        ifu_rvalid = 1'b1; inst_in = 32'h0040_a283;
        tick();
        exp_inst = 32'h0040_a283;
        ifu_rvalid = 1'b0;
        expect_push(3'd2, 0, 0, 0, 0, 0, 0);
        check_cycle("midmem/decode");
        tick();
        expect_push(3'd3, 0, 1, 0, 0, 0, 0);
        check_cycle("midmem/mem0");
        tick();
        expect_push(3'd3, 0, 1, 0, 0, 0, 0);
        check_cycle("midmem/mem1");
        do_reset("reset_midmem");

        // Reset in the middle of FETCH.
        expect_push(3'd1, 1, 0, 0, 0, 0, 0);
        check_cycle("midfetch/fetch0");
        tick();
        expect_push(3'd1, 1, 0, 0, 0, 0, 0);
        check_cycle("midfetch/fetch1");
        do_reset("reset_midfetch");

        // After the resets the block must still run normally.
        run_instr(tbl[0], "post_reset_addi");

`ifdef YSYX_23060042_PERF_EN
        do_reset("reset_perf");
        for (int i = 0; i < 10; i++) begin
            run_instr(tbl[0], $sformatf("perf_addi%0d", i));
        end
        total++;
        if (minstret !== 64'd10) begin
            bad++;
            $display("FAIL perf_minstret: got %0d want 10", minstret);
        end
        // One IDLE edge plus three edges per instruction.
        total++;
        if (mcycle !== 64'd31) begin
            bad++;
            $display("FAIL perf_mcycle: got %0d want 31", mcycle);
        end
`endif

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expected: got %0d entries want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_23060042_ctrl.md
YSYX_23060042_CTRL -- requirements
Module: ysyx_23060042_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, max wait cycles for a fetch/LSU handshake before error.
REQ-002 SHALL have port clk  input  1  single core clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ifu_req  output  1  instruction fetch request.
REQ-005 SHALL have port ifu_rvalid  input  1  fetch data valid this cycle.
REQ-006 SHALL have port inst_in  input  32  fetched instruction word.
REQ-007 SHALL have port inst  output  32  latched instruction register driving the decoder.
REQ-008 SHALL have inputs Regen 1, Pcjen 1, Mwen 2, Mren 2, Brken 1  decoder micro-command fields for inst.
REQ-009 SHALL have port lsu_req  output  1  load/store request.
REQ-010 SHALL have port lsu_done  input  1  load/store completed this cycle.
REQ-011 SHALL have ports reg_we  output  1 and pc_we  output  1  register-file and PC write strobes.
REQ-012 SHALL have ports halt  output  1 (ebreak reached) and err  output  1 (handshake timeout).
REQ-013 SHALL have port state  output  3  current FSM state, for debug.

Function
REQ-014 SHALL implement states IDLE=0, FETCH=1, DECODE=2, MEM=3, WB=4, HALT=5, ERROR=6.
REQ-015 IDLE SHALL go to FETCH unconditionally on the next edge.
REQ-016 FETCH SHALL hold ifu_req=1. On ifu_rvalid=1: latch inst_in into inst, go to DECODE; this includes rvalid in the first FETCH cycle.
REQ-017 DECODE SHALL last exactly 1 cycle, then branch by priority:
  - Brken=1 -> HALT;
  - Mren!=0 or Mwen!=0 -> MEM;
  - otherwise -> WB.
REQ-018 MEM SHALL hold lsu_req=1 until lsu_done=1, then go to WB.
REQ-019 WB SHALL last 1 cycle with pc_we=1 and reg_we=Regen, then go to FETCH.
REQ-020 reg_we and pc_we SHALL be 0 in every state except WB.
REQ-021 A wait counter SHALL:
  - clear on entry to FETCH or MEM;
  - increment each cycle without a handshake;
  - when it reaches MEM_TIMEOUT with no handshake that cycle, go to ERROR.
REQ-022 A handshake arriving in the same cycle the counter reaches MEM_TIMEOUT SHALL take priority over the timeout.
REQ-023 lsu_done outside MEM and ifu_rvalid outside FETCH SHALL be ignored.
REQ-024 HALT SHALL drive halt=1, and ERROR SHALL drive err=1. Both states are sticky until rst, with all request and strobe outputs 0.
REQ-025 Minimum instruction latency SHALL be 3 cycles for a non-memory instruction with immediate rvalid: FETCH, DECODE, WB.
REQ-026 inst SHALL change only on a FETCH handshake.

Reset
REQ-027 rst=1 SHALL immediately, asynchronously:
  - set state=IDLE;
  - set inst=32'h00000013 (nop);
  - clear the wait counter;
  - drive ifu_req, lsu_req, reg_we, pc_we, halt and err to 0.
REQ-028 Reset asserted mid-FETCH or mid-MEM SHALL abandon the transaction; no write strobe is issued.

Configuration
REQ-029 With YSYX_23060042_PERF_EN defined, the block SHALL add output ports mcycle (64) and minstret (64), both reset to 0:
  - mcycle increments every cycle outside HALT/ERROR;
  - minstret increments on each WB cycle;
  - both wrap modulo 2^64.
REQ-030 Without YSYX_23060042_PERF_EN, these ports and counters SHALL NOT exist, and behaviour is otherwise identical.

Verification
REQ-031 addi, rvalid in the first FETCH cycle -> states 1,2,4,1; reg_we=1 and pc_we=1 in the WB cycle only.
REQ-032 lw (Mren=2'b01), lsu_done 3 cycles after MEM entry -> lsu_req high 4 cycles, then WB with reg_we=1.
REQ-033 sw (Mwen=2'b11, Regen=0) -> MEM then WB with reg_we=0, pc_we=1.
REQ-034 Brken=1 in DECODE -> halt=1 next cycle and sticky; ifu_req stays 0 for 100 cycles.
REQ-035 MEM_TIMEOUT=4, ifu_rvalid never asserted -> err=1 after 5 FETCH cycles. Second run with rvalid exactly at count 4 -> DECODE, no error.
REQ-036 rst asserted mid-MEM -> outputs 0 in the same cycle, state=0. With PERF_EN, 10 addi instructions give minstret=10.
